// File: rtl/dag_burst_seq_pkg.sv
// Shared types and defaults for the DAG burst sequencer.
package dag_burst_seq_pkg;

    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned STARVE_DEF = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dag_starve_ctr.sv
// Counts consecutive blocked burst cycles; flags when the burst has waited long enough.
module dag_starve_ctr #(
    parameter int unsigned STARVE = 8
) (
    input  logic clk_rf,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_win_c
);

    localparam int unsigned CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    logic [CW-1:0] r_cnt;

    // Saturates at STARVE so a long blocked stretch never wraps back to zero.
    always_ff @(posedge clk_rf) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CW'(STARVE))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_win_c = (r_cnt == CW'(STARVE));

endmodule

// File: rtl/dag_burst_seq.sv
// Interleaves burst post-modify DAG requests with instruction DAG requests.
module dag_burst_seq
    import dag_burst_seq_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned STARVE = STARVE_DEF
) (
    input  logic             clk_rf,
    input  logic             rst,
    input  logic             ps_en,
    input  logic             ps_dgsclt,
    input  logic             ps_mdfy,
    input  logic [IDX_W-1:0] ps_iadd,
    input  logic [IDX_W-1:0] ps_madd,
    output logic             ps_stall,
    input  logic             bq_vld,
    output logic             bq_rdy,
    input  logic             bq_dgsclt,
    input  logic [IDX_W-1:0] bq_iadd,
    input  logic [IDX_W-1:0] bq_madd,
    input  logic [CNT_W-1:0] bq_cnt,
    input  logic             bq_abort,
    output logic             bq_busy,
    output logic             bq_done,
    output logic [CNT_W-1:0] bq_left,
    input  logic             mem_rdy,
    output logic             dg_en,
    output logic             dg_dgsclt,
    output logic             dg_mdfy,
    output logic [IDX_W-1:0] dg_iadd,
    output logic [IDX_W-1:0] dg_madd
);

    state_e             r_state;
    logic               r_dgsclt;
    logic [IDX_W-1:0]   r_iadd;
    logic [IDX_W-1:0]   r_madd;
    logic [CNT_W-1:0]   r_left;

    logic w_run;
    logic w_win;
    logic w_go;
    logic w_inc;
    logic w_clr;

    assign w_run = (r_state == ST_RUN);
    assign w_go  = w_run & mem_rdy & ~bq_abort & (~ps_en | w_win);
    assign w_inc = w_run & mem_rdy & ps_en & ~w_go;
    // Abort is the only way out of RUN without a slot, so it clears the count too.
    assign w_clr = ~w_run | w_go | bq_abort;

    dag_starve_ctr #(
        .STARVE (STARVE)
    ) u_starve (
        .clk_rf  (clk_rf),
        .rst     (rst),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_win_c (w_win)
    );

    always_ff @(posedge clk_rf) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_dgsclt <= 1'b0;
            r_iadd   <= '0;
            r_madd   <= '0;
            r_left   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bq_vld) begin
                        r_dgsclt <= bq_dgsclt;
                        r_iadd   <= bq_iadd;
                        r_madd   <= bq_madd;
                        r_left   <= bq_cnt;
                        r_state  <= (bq_cnt == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Residual count is kept on abort so software can see what was left.
                    if (bq_abort) begin
                        r_state <= ST_DONE;
                    end else if (w_go) begin
                        r_left <= r_left - CNT_W'(1);
                        if (r_left == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bq_rdy   = (r_state == ST_IDLE);
    assign bq_busy  = w_run;
    assign bq_done  = (r_state == ST_DONE);
    assign bq_left  = r_left;
    assign ps_stall = ps_en & w_go;

    // Burst slot wins the DAG port; otherwise the instruction request passes straight through.
    always_comb begin
        dg_en     = 1'b0;
        dg_dgsclt = 1'b0;
        dg_mdfy   = 1'b0;
        dg_iadd   = '0;
        dg_madd   = '0;
        if (w_go) begin
            dg_en     = 1'b1;
            dg_dgsclt = r_dgsclt;
            dg_iadd   = r_iadd;
            dg_madd   = r_madd;
        end else if (ps_en) begin
            dg_en     = 1'b1;
            dg_dgsclt = ps_dgsclt;
            dg_mdfy   = ps_mdfy;
            dg_iadd   = ps_iadd;
            dg_madd   = ps_madd;
        end
    end

endmodule

// File: tb/tb_dag_burst_seq.sv
// Self-checking bench for dag_burst_seq: directed table, corner sequences, random vs model.
module tb_dag_burst_seq;

    localparam int STARVE = 8;

    typedef struct packed {
        logic        rst;
        logic        ps_en;
        logic        ps_sel;
        logic        ps_mdfy;
        logic [2:0]  ps_i;
        logic [2:0]  ps_m;
        logic        vld;
        logic        b_sel;
        logic [2:0]  b_i;
        logic [2:0]  b_m;
        logic [15:0] cnt;
        logic        abort;
        logic        mem;
    } in_t;

    typedef struct packed {
        logic        rdy;
        logic        busy;
        logic        done;
        logic        stall;
        logic        en;
        logic        sel;
        logic        mdfy;
        logic [2:0]  i;
        logic [2:0]  m;
        logic [15:0] left;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        clk_rf = 1'b0;
    logic        rst = 1'b1;
    logic        ps_en = 1'b0, ps_dgsclt = 1'b0, ps_mdfy = 1'b0;
    logic [2:0]  ps_iadd = '0, ps_madd = '0;
    logic        ps_stall;
    logic        bq_vld = 1'b0, bq_dgsclt = 1'b0, bq_abort = 1'b0, mem_rdy = 1'b0;
    logic [2:0]  bq_iadd = '0, bq_madd = '0;
    logic [15:0] bq_cnt = '0;
    logic        bq_rdy, bq_busy, bq_done;
    logic [15:0] bq_left;
    logic        dg_en, dg_dgsclt, dg_mdfy;
    logic [2:0]  dg_iadd, dg_madd;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: a pending burst, a pending completion flag, word budget, wait count.
    bit         m_active, m_done;
    int         m_left, m_starve;
    logic       m_sel;
    logic [2:0] m_i, m_m;

    always #5 clk_rf = ~clk_rf;

    dag_burst_seq #(.CNT_W(16), .STARVE(STARVE)) dut (
        .clk_rf    (clk_rf),
        .rst       (rst),
        .ps_en     (ps_en),
        .ps_dgsclt (ps_dgsclt),
        .ps_mdfy   (ps_mdfy),
        .ps_iadd   (ps_iadd),
        .ps_madd   (ps_madd),
        .ps_stall  (ps_stall),
        .bq_vld    (bq_vld),
        .bq_rdy    (bq_rdy),
        .bq_dgsclt (bq_dgsclt),
        .bq_iadd   (bq_iadd),
        .bq_madd   (bq_madd),
        .bq_cnt    (bq_cnt),
        .bq_abort  (bq_abort),
        .bq_busy   (bq_busy),
        .bq_done   (bq_done),
        .bq_left   (bq_left),
        .mem_rdy   (mem_rdy),
        .dg_en     (dg_en),
        .dg_dgsclt (dg_dgsclt),
        .dg_mdfy   (dg_mdfy),
        .dg_iadd   (dg_iadd),
        .dg_madd   (dg_madd)
    );

    function automatic in_t I(logic r, logic pe, logic ps, logic pm, logic [2:0] pi, logic [2:0] pmm,
                              logic vl, logic bs, logic [2:0] bi, logic [2:0] bm, logic [15:0] c,
                              logic ab, logic mr);
        in_t v;
        v.rst = r; v.ps_en = pe; v.ps_sel = ps; v.ps_mdfy = pm; v.ps_i = pi; v.ps_m = pmm;
        v.vld = vl; v.b_sel = bs; v.b_i = bi; v.b_m = bm; v.cnt = c; v.abort = ab; v.mem = mr;
        return v;
    endfunction

    function automatic out_t O(logic rd, logic bz, logic dn, logic st, logic en, logic sl, logic md,
                               logic [2:0] ii, logic [2:0] mm, logic [15:0] lf);
        out_t o;
        o.rdy = rd; o.busy = bz; o.done = dn; o.stall = st; o.en = en; o.sel = sl; o.mdfy = md;
        o.i = ii; o.m = mm; o.left = lf;
        return o;
    endfunction

    function automatic in_t quiet();
        return I(0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 3'd0, 16'd0, 0, 1);
    endfunction

    function automatic out_t model_out(in_t v);
        out_t o;
        bit slot;
        o = '0;
        o.rdy  = !m_active && !m_done;
        o.busy = m_active;
        o.done = m_done;
        o.left = 16'(m_left);
        slot = m_active && v.mem && !v.abort && (!v.ps_en || m_starve == STARVE);
        if (slot) begin
            o.en = 1'b1; o.sel = m_sel; o.i = m_i; o.m = m_m; o.stall = v.ps_en;
        end else if (v.ps_en) begin
            o.en = 1'b1; o.sel = v.ps_sel; o.mdfy = v.ps_mdfy; o.i = v.ps_i; o.m = v.ps_m;
        end
        return o;
    endfunction

    task automatic model_step(input in_t v);
        bit slot;
        slot = m_active && v.mem && !v.abort && (!v.ps_en || m_starve == STARVE);
        if (v.rst) begin
            m_active = 0; m_done = 0; m_left = 0; m_starve = 0;
            m_sel = 1'b0; m_i = '0; m_m = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (v.abort) begin
                m_active = 0; m_done = 1; m_starve = 0;
            end else if (slot) begin
                m_left = m_left - 1;
                m_starve = 0;
                if (m_left == 0) begin
                    m_active = 0; m_done = 1;
                end
            end else if (v.mem && v.ps_en && m_starve < STARVE) begin
                m_starve = m_starve + 1;
            end
        end else if (v.vld) begin
            m_sel = v.b_sel; m_i = v.b_i; m_m = v.b_m; m_left = int'(v.cnt);
            if (v.cnt == 16'd0) m_done = 1;
            else m_active = 1;
        end
    endtask

    task automatic check_out(input string nm, input out_t act, input out_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (rdy busy done stall en sel mdfy i m left)", nm, act, exp);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered just after a rising edge: drive, sample mid-cycle, compare to model, advance.
    task automatic cycle(input in_t v, output out_t act);
        out_t exp;
        rst = v.rst; ps_en = v.ps_en; ps_dgsclt = v.ps_sel; ps_mdfy = v.ps_mdfy;
        ps_iadd = v.ps_i; ps_madd = v.ps_m; bq_vld = v.vld; bq_dgsclt = v.b_sel;
        bq_iadd = v.b_i; bq_madd = v.b_m; bq_cnt = v.cnt; bq_abort = v.abort; mem_rdy = v.mem;
        @(negedge clk_rf);
        act = '{rdy: bq_rdy, busy: bq_busy, done: bq_done, stall: ps_stall, en: dg_en,
                sel: dg_dgsclt, mdfy: dg_mdfy, i: dg_iadd, m: dg_madd, left: bq_left};
        exp = model_out(v);
        check_out("model", act, exp);
        @(posedge clk_rf);
        model_step(v);
        #1;
    endtask

    task automatic do_reset();
        in_t v;
        v = quiet();
        v.rst = 1'b1;
        rst = 1'b1;
        @(posedge clk_rf);
        @(posedge clk_rf);
        model_step(v);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        out_t act;
        in_t  v;
        int   issues, first_slot, second_slot;

        // bq_cnt=4 burst, DONE with ignored bq_vld and passthrough, then a zero-length burst.
        tbl[0]  = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(1,0,0,0, 0,0,0,3'd0,3'd0,16'd0)};
        tbl[1]  = {I(0,1,1,1,3'd2,3'd7, 0,0,3'd0,3'd0,16'd0,0,1), O(1,0,0,0, 1,1,1,3'd2,3'd7,16'd0)};
        tbl[2]  = {I(0,0,0,0,3'd0,3'd0, 1,1,3'd5,3'd3,16'd4,0,1), O(1,0,0,0, 0,0,0,3'd0,3'd0,16'd0)};
        tbl[3]  = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(0,1,0,0, 1,1,0,3'd5,3'd3,16'd4)};
        tbl[4]  = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(0,1,0,0, 1,1,0,3'd5,3'd3,16'd3)};
        tbl[5]  = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(0,1,0,0, 1,1,0,3'd5,3'd3,16'd2)};
        tbl[6]  = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(0,1,0,0, 1,1,0,3'd5,3'd3,16'd1)};
        tbl[7]  = {I(0,1,0,1,3'd4,3'd1, 1,0,3'd6,3'd6,16'd9,0,1), O(0,0,1,0, 1,0,1,3'd4,3'd1,16'd0)};
        tbl[8]  = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(1,0,0,0, 0,0,0,3'd0,3'd0,16'd0)};
        tbl[9]  = {I(0,0,0,0,3'd0,3'd0, 1,1,3'd1,3'd2,16'd0,0,1), O(1,0,0,0, 0,0,0,3'd0,3'd0,16'd0)};
        tbl[10] = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(0,0,1,0, 0,0,0,3'd0,3'd0,16'd0)};
        tbl[11] = {I(0,0,0,0,3'd0,3'd0, 0,0,3'd0,3'd0,16'd0,0,1), O(1,0,0,0, 0,0,0,3'd0,3'd0,16'd0)};

        do_reset();
        for (int j = 0; j < 12; j++) begin
            cycle(tbl[j].in, act);
            check_out($sformatf("vec%0d", j), act, tbl[j].exp);
        end

        // bq_cnt=3 with mem_rdy toggling 1,0,1,0,1.
        v = quiet(); v.vld = 1'b1; v.b_sel = 1'b0; v.b_i = 3'd3; v.b_m = 3'd4; v.cnt = 16'd3;
        cycle(v, act);
        issues = 0;
        for (int k = 0; k < 5; k++) begin
            v = quiet(); v.mem = ((k % 2) == 0);
            cycle(v, act);
            if (act.en) issues++;
            if (k == 1) check_val("toggle_left_hold", int'(act.left), 2);
        end
        check_val("toggle_issues", issues, 3);
        cycle(quiet(), act);
        check_val("toggle_done", int'(act.done), 1);
        cycle(quiet(), act);

        // bq_cnt=2 under constant instruction traffic: burst wins only after STARVE blocked cycles.
        v = quiet(); v.ps_en = 1'b1; v.ps_mdfy = 1'b1; v.ps_i = 3'd1; v.ps_m = 3'd6;
        v.vld = 1'b1; v.b_sel = 1'b1; v.b_i = 3'd7; v.b_m = 3'd2; v.cnt = 16'd2;
        cycle(v, act);
        first_slot = -1; second_slot = -1;
        for (int k = 1; k <= 20; k++) begin
            v.vld = 1'b0;
            cycle(v, act);
            if (act.stall && first_slot < 0) first_slot = k;
            else if (act.stall && second_slot < 0) second_slot = k;
            if (k == 8) check_val("starve_pass_i", int'(act.i), 1);
            if (k == 9) check_val("starve_slot_i", int'(act.i), 7);
        end
        check_val("starve_first", first_slot, STARVE + 1);
        check_val("starve_second", second_slot, 2 * (STARVE + 1));

        // bq_cnt=5 aborted after two issues.
        v = quiet(); v.vld = 1'b1; v.b_i = 3'd2; v.b_m = 3'd5; v.cnt = 16'd5;
        cycle(v, act);
        cycle(quiet(), act);
        cycle(quiet(), act);
        v = quiet(); v.abort = 1'b1;
        cycle(v, act);
        check_val("abort_no_issue", int'(act.en), 0);
        cycle(quiet(), act);
        check_val("abort_done", int'(act.done), 1);
        check_val("abort_left", int'(act.left), 3);
        cycle(quiet(), act);

        // Reset in the middle of a burst.
        v = quiet(); v.vld = 1'b1; v.b_i = 3'd6; v.cnt = 16'd4;
        cycle(v, act);
        cycle(quiet(), act);
        v = quiet(); v.rst = 1'b1;
        cycle(v, act);
        cycle(quiet(), act);
        check_val("rst_rdy", int'(act.rdy), 1);
        check_val("rst_left", int'(act.left), 0);
        check_val("rst_busy", int'(act.busy), 0);
        for (int k = 0; k < 3; k++) begin
            cycle(quiet(), act);
            check_val("rst_no_done", int'(act.done), 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            v.rst     = ($urandom_range(0, 149) == 0);
            v.ps_en   = ($urandom_range(0, 9) < 7);
            v.ps_sel  = 1'($urandom);
            v.ps_mdfy = 1'($urandom);
            v.ps_i    = 3'($urandom);
            v.ps_m    = 3'($urandom);
            v.vld     = ($urandom_range(0, 3) == 0);
            v.b_sel   = 1'($urandom);
            v.b_i     = 3'($urandom);
            v.b_m     = 3'($urandom);
            v.cnt     = 16'($urandom_range(0, 6));
            v.abort   = ($urandom_range(0, 29) == 0);
            v.mem     = ($urandom_range(0, 3) != 0);
            cycle(v, act);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
